// File: rtl/thermo_pkg.sv
// Shared types and helpers for the thermometer mask pipeline.
// Fill helpers work at a fixed maximum width; callers slice the low bits they need.
package thermo_pkg;

    typedef enum logic [1:0] {
        LOW_FILL  = 2'd0,
        HIGH_FILL = 2'd1,
        RANGE     = 2'd2,
        RANGE_INV = 2'd3
    } thermo_mode_t;

    // Widest supported index operand is THERMO_IDX_W-1 bits (mask up to 128 bits).
    localparam int THERMO_IDX_W = 8;
    localparam int THERMO_MAX_W = 2 ** THERMO_IDX_W;

    // Low fill of k ones: one-hot of k, then a log-depth prefix OR toward bit 0.
    // Bit i of the result is set when the one-hot bit sits strictly above i.
    function automatic logic [THERMO_MAX_W-1:0] thermo_low(input logic [THERMO_IDX_W:0] k);
        logic [THERMO_MAX_W:0] spread;
        spread = (THERMO_MAX_W + 1)'(1) << k;
        for (int d = 1; d <= THERMO_MAX_W; d = d * 2) begin
            spread = spread | (spread >> d);
        end
        return spread[THERMO_MAX_W:1];
    endfunction

    // Thermometer fill of k ones inside an n_bits wide field.
    // The high variant sets bits [n_bits-1 : n_bits-k], matching the legacy decoder.
    function automatic logic [THERMO_MAX_W-1:0] thermo_fill(input logic [THERMO_IDX_W:0] k,
                                                            input logic                  high,
                                                            input logic [THERMO_IDX_W:0] n_bits);
        logic [THERMO_MAX_W-1:0] result;
        if (high) begin
            result = thermo_low(n_bits) & ~thermo_low(n_bits - k);
        end else begin
            result = thermo_low(k);
        end
        return result;
    endfunction

endpackage

// File: rtl/thermometer_mask_core.sv
// Combinational mask generator: two fill modes plus inclusive range and its inverse.
// Range is LOW_FILL(hi+1) & ~LOW_FILL(lo), so lo > hi naturally yields zero.
module thermometer_mask_core
    import thermo_pkg::*;
#(
    parameter  int InBitWidth  = 5,
    localparam int OutBitWidth = 2 ** InBitWidth
) (
    input  thermo_mode_t            mode,
    input  logic [InBitWidth-1:0]   lo,
    input  logic [InBitWidth-1:0]   hi,
    output logic [OutBitWidth-1:0]  mask
);

    localparam int IdxPad = THERMO_IDX_W + 1 - InBitWidth;

    logic [THERMO_IDX_W:0]   lo_ext;
    logic [THERMO_IDX_W:0]   hi_plus_one;
    logic [THERMO_IDX_W:0]   n_ext;
    logic [THERMO_MAX_W-1:0] fill_lo_full;
    logic [THERMO_MAX_W-1:0] fill_hi_full;
    logic [THERMO_MAX_W-1:0] fill_hp_full;
    logic [OutBitWidth-1:0]  range_mask;
    logic                    unused_fill_bits;

    // Bits above the configured mask width are always zero and intentionally dropped.
    assign unused_fill_bits = ^{fill_lo_full[THERMO_MAX_W-1:OutBitWidth],
                                fill_hi_full[THERMO_MAX_W-1:OutBitWidth],
                                fill_hp_full[THERMO_MAX_W-1:OutBitWidth]};

    // Build the three fills, combine into the range mask, then pick by mode.
    always_comb begin
        lo_ext       = {{IdxPad{1'b0}}, lo};
        hi_plus_one  = {{IdxPad{1'b0}}, hi} + (THERMO_IDX_W + 1)'(1);
        n_ext        = (THERMO_IDX_W + 1)'(OutBitWidth);
        fill_lo_full = thermo_fill(lo_ext, 1'b0, n_ext);
        fill_hi_full = thermo_fill(lo_ext, 1'b1, n_ext);
        fill_hp_full = thermo_fill(hi_plus_one, 1'b0, n_ext);
        range_mask   = fill_hp_full[OutBitWidth-1:0] & ~fill_lo_full[OutBitWidth-1:0];
        mask         = '0;
        unique case (mode)
            LOW_FILL:  mask = fill_lo_full[OutBitWidth-1:0];
            HIGH_FILL: mask = fill_hi_full[OutBitWidth-1:0];
            RANGE:     mask = range_mask;
            RANGE_INV: mask = ~range_mask;
            default:   mask = '0;
        endcase
    end

endmodule

// File: rtl/thermometer_mask_pipe.sv
// Two-stage pipelined mask generator with valid/ready flow control.
// Stage 1 holds the computed mask and tag, stage 2 adds the popcount.
module thermometer_mask_pipe
    import thermo_pkg::*;
#(
    parameter  int InBitWidth  = 5,
    parameter  int TagWidth    = 4,
    localparam int OutBitWidth = 2 ** InBitWidth
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_mode,
    input  logic [InBitWidth-1:0]  in_lo,
    input  logic [InBitWidth-1:0]  in_hi,
    input  logic [TagWidth-1:0]    in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OutBitWidth-1:0] out_mask,
    output logic [InBitWidth:0]    out_ones,
    output logic [TagWidth-1:0]    out_tag
);

    logic                   advance;
    logic                   accept;
    logic [OutBitWidth-1:0] core_mask;

    logic                   s1_valid_q, s1_valid_d;
    logic [OutBitWidth-1:0] s1_mask_q,  s1_mask_d;
    logic [TagWidth-1:0]    s1_tag_q,   s1_tag_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [OutBitWidth-1:0] s2_mask_q,  s2_mask_d;
    logic [InBitWidth:0]    s2_ones_q,  s2_ones_d;
    logic [TagWidth-1:0]    s2_tag_q,   s2_tag_d;
    logic [InBitWidth:0]    ones_sum;

    thermometer_mask_core #(
        .InBitWidth (InBitWidth)
    ) u_core (
        .mode (thermo_mode_t'(in_mode)),
        .lo   (in_lo),
        .hi   (in_hi),
        .mask (core_mask)
    );

    // Handshake: stage 2 frees up when empty or drained; stage 1 may accept when it can move on.
    always_comb begin
        advance  = !s2_valid_q || out_ready;
        in_ready = !rst && (!s1_valid_q || advance);
        accept   = in_valid && in_ready;
    end

    // Popcount of the registered stage-1 mask.
    always_comb begin
        ones_sum = '0;
        for (int i = 0; i < OutBitWidth; i++) begin
            ones_sum = ones_sum + {{InBitWidth{1'b0}}, s1_mask_q[i]};
        end
    end

    // Next-state for both stages; data registers hold when not loading so stalls keep outputs stable.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mask_d  = s1_mask_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_mask_d  = s2_mask_q;
        s2_ones_d  = s2_ones_q;
        s2_tag_d   = s2_tag_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_mask_d  = core_mask;
            s1_tag_d   = in_tag;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end
        if (advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_mask_d = s1_mask_q;
                s2_ones_d = ones_sum;
                s2_tag_d  = s1_tag_q;
            end
        end
    end

    // Pipeline registers with synchronous reset discarding anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mask_q  <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_mask_q  <= '0;
            s2_ones_q  <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mask_q  <= s1_mask_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_mask_q  <= s2_mask_d;
            s2_ones_q  <= s2_ones_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_mask  = s2_mask_q;
    assign out_ones  = s2_ones_q;
    assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_thermometer_mask_pipe.sv
// Self-checking bench for thermometer_mask_pipe at the default widths (32-bit mask).
module tb_thermometer_mask_pipe;

    typedef struct packed {
        logic [1:0] mode;
        logic [4:0] lo;
        logic [4:0] hi;
        logic [3:0] tag;
    } req_t;

    typedef struct packed {
        logic [31:0] mask;
        logic [5:0]  ones;
        logic [3:0]  tag;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [4:0]  in_lo;
    logic [4:0]  in_hi;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_mask;
    logic [5:0]  out_ones;
    logic [3:0]  out_tag;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int first_out;
    int last_out;
    int n_out;
    int stall_accepts;

    req_t req_q[$];
    exp_t exp_q[$];

    thermometer_mask_pipe #(
        .InBitWidth (5),
        .TagWidth   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_lo     (in_lo),
        .in_hi     (in_hi),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_ones  (out_ones),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop so a wedged pipeline can never hang the run.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Bit-by-bit reference; HIGH_FILL follows the legacy decoder (bits >= N-k set).
    function automatic logic [31:0] modelMask(input logic [1:0] mode, input int lo, input int hi);
        logic [31:0] m;
        for (int i = 0; i < 32; i++) begin
            case (mode)
                2'd0:    m[i] = (i < lo);
                2'd1:    m[i] = (i >= 32 - lo);
                2'd2:    m[i] = (i >= lo) && (i <= hi);
                default: m[i] = !((i >= lo) && (i <= hi));
            endcase
        end
        return m;
    endfunction

    function automatic exp_t makeExp(input req_t r);
        exp_t e;
        e.mask = modelMask(r.mode, int'(r.lo), int'(r.hi));
        e.ones = 6'($countones(e.mask));
        e.tag  = r.tag;
        return e;
    endfunction

    task automatic applyStimulus(input logic [1:0] mode, input logic [4:0] lo, input logic [4:0] hi,
                                 input logic [3:0] tag);
        in_valid = 1'b1;
        in_mode  = mode;
        in_lo    = lo;
        in_hi    = hi;
        in_tag   = tag;
    endtask

    // Single request into an empty pipe: result must appear exactly two cycles after acceptance.
    task automatic runDirected(input logic [1:0] mode, input logic [4:0] lo, input logic [4:0] hi,
                               input logic [3:0] tag, input logic [31:0] exp_mask, input logic [5:0] exp_ones);
        @(posedge clk); #1;
        out_ready = 1'b1;
        applyStimulus(mode, lo, hi, tag);
        @(negedge clk);
        checkOutput("dir_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("dir_latency_early", out_valid, 0);
        @(negedge clk);
        checkOutput("dir_out_valid", out_valid, 1);
        checkOutput("dir_mask", out_mask, exp_mask);
        checkOutput("dir_ones", out_ones, exp_ones);
        checkOutput("dir_tag", out_tag, tag);
    endtask

    // Streams req_q through the DUT with random valid/ready and scores every output against exp_q.
    task automatic runStream(input int p_valid, input int p_ready);
        req_t r;
        exp_t e;
        int   budget;
        budget    = 20 * (req_q.size() + 4) + 200;
        cyc       = 0;
        n_out     = 0;
        first_out = 0;
        last_out  = 0;
        while ((req_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (req_q.size() != 0 && $urandom_range(99) < p_valid) begin
                r = req_q[0];
                applyStimulus(r.mode, r.lo, r.hi, r.tag);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(99) < p_ready);
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("stream_spurious", 1, 0);
                end else begin
                    e = exp_q[0];
                    checkOutput("stream_mask", out_mask, e.mask);
                    checkOutput("stream_ones", out_ones, e.ones);
                    checkOutput("stream_tag", out_tag, e.tag);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        if (n_out == 0) first_out = cyc;
                        last_out = cyc;
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                r = req_q.pop_front();
                exp_q.push_back(makeExp(r));
            end
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (cyc >= budget) begin
            checkOutput("stream_timeout", 64'(req_q.size() + exp_q.size()), 0);
            req_q.delete();
            exp_q.delete();
        end
    endtask

    initial begin
        req_t r;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 2'd0;
        in_lo     = '0;
        in_hi     = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        // Reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", in_ready, 1);
        checkOutput("post_rst_out_valid", out_valid, 0);
        checkOutput("post_rst_mask", out_mask, 0);
        checkOutput("post_rst_ones", out_ones, 0);
        checkOutput("post_rst_tag", out_tag, 0);

        // Directed vectors with hand-computed results
        runDirected(2'd1, 5'd3,  5'd0,  4'h5, 32'hE000_0000, 6'd3);
        runDirected(2'd1, 5'd31, 5'd0,  4'h6, 32'hFFFF_FFFE, 6'd31);
        runDirected(2'd0, 5'd0,  5'd0,  4'h1, 32'h0000_0000, 6'd0);
        runDirected(2'd0, 5'd31, 5'd0,  4'h2, 32'h7FFF_FFFF, 6'd31);
        runDirected(2'd2, 5'd4,  5'd7,  4'h3, 32'h0000_00F0, 6'd4);
        runDirected(2'd2, 5'd0,  5'd31, 4'h4, 32'hFFFF_FFFF, 6'd32);
        runDirected(2'd2, 5'd9,  5'd3,  4'h7, 32'h0000_0000, 6'd0);
        runDirected(2'd2, 5'd5,  5'd5,  4'h8, 32'h0000_0020, 6'd1);
        runDirected(2'd3, 5'd4,  5'd7,  4'h9, 32'hFFFF_FF0F, 6'd28);
        runDirected(2'd3, 5'd9,  5'd3,  4'hA, 32'hFFFF_FFFF, 6'd32);
        runDirected(2'd3, 5'd0,  5'd31, 4'hB, 32'h0000_0000, 6'd0);

        // HIGH_FILL sweep k=0..31 against the legacy decoder model
        for (int k = 0; k < 32; k++) begin
            r.mode = 2'd1;
            r.lo   = 5'(k);
            r.hi   = 5'(31 - k);
            r.tag  = 4'(k);
            req_q.push_back(r);
        end
        runStream(100, 100);

        // Eight back-to-back requests must leave in eight consecutive cycles
        for (int t = 0; t < 8; t++) begin
            r.mode = 2'd2;
            r.lo   = 5'(t);
            r.hi   = 5'(t + 3);
            r.tag  = 4'(t);
            req_q.push_back(r);
        end
        runStream(100, 100);
        checkOutput("b2b_count", 64'(n_out), 8);
        checkOutput("b2b_span", 64'(last_out - first_out), 7);

        // Stall: out_ready low for 5 cycles fills the pipe after exactly two accepts
        stall_accepts = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            out_ready = 1'b0;
            applyStimulus(2'd0, 5'(8 + stall_accepts), 5'd0, 4'(8 + stall_accepts));
            @(negedge clk);
            if (in_valid && in_ready) stall_accepts++;
        end
        checkOutput("stall_accepts", 64'(stall_accepts), 2);
        checkOutput("stall_in_ready", in_ready, 0);
        checkOutput("stall_out_valid", out_valid, 1);
        checkOutput("stall_hold_tag", out_tag, 4'd8);
        checkOutput("stall_hold_mask", out_mask, 32'h0000_00FF);
        checkOutput("stall_hold_ones", out_ones, 6'd8);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("resume_first_valid", out_valid, 1);
        checkOutput("resume_first_tag", out_tag, 4'd8);
        @(negedge clk);
        checkOutput("resume_second_valid", out_valid, 1);
        checkOutput("resume_second_tag", out_tag, 4'd9);
        checkOutput("resume_second_mask", out_mask, 32'h0000_01FF);
        @(negedge clk);
        checkOutput("resume_drained", out_valid, 0);

        // Random backpressure over 10k requests
        for (int i = 0; i < 10000; i++) begin
            r.mode = 2'($urandom_range(3));
            r.lo   = 5'($urandom_range(31));
            r.hi   = 5'($urandom_range(31));
            r.tag  = 4'(i);
            req_q.push_back(r);
        end
        runStream(70, 60);

        // Reset with two requests in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(2'd0, 5'd3, 5'd0, 4'hA);
        @(posedge clk); #1;
        applyStimulus(2'd1, 5'd2, 5'd0, 4'hB);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("inflight_out_valid", out_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        checkOutput("midrst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("midrst_no_stale", out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
